bcd_display_formatter: RTL and testbench



---
 rtl/disp_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_display_formatter.sv | 126 ++++++++++++
 tb/tb_bcd_display_formatter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display codes, FSM states and constants for
// the binary-to-BCD display formatter.
package disp_pkg;

  localparam logic [3:0] BCD_UNDERSCORE = 4'hA;
  localparam logic [3:0] BCD_CLEAR      = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FORMAT
  } state_e;

  // 10^n, wide enough for any supported BIN_W+1 compare
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the
// digit is 5 or more, before the next left shift.
module bcd_digit_adj
  import disp_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-BCD converter with leading-zero
// blanking and overflow marking for 7-seg digits.
module bcd_display_formatter
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        value,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] digit_codes
);

  localparam int          BW    = 4 * NUM_DIGITS;
  localparam int          CW    = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  state_e          state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            blz_q, blz_d;
  logic [BW-1:0]   codes_q, codes_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   fmt;
  logic [63:0]     value_ext;
  logic            lead;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign value_ext = {{(64-BIN_W){1'b0}}, value};

  // Zeros above the first nonzero digit blank; digit 0 never does
  always_comb begin
    fmt  = bcd_q;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      if (lead && blz_q) begin
        fmt[4*i +: 4] = BCD_CLEAR;
      end
    end
    if (ovf_q) begin
      fmt = {NUM_DIGITS{BCD_UNDERSCORE}};
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    blz_d   = blz_q;
    codes_d = codes_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          blz_d   = blank_lz;
          ovf_d   = (value_ext >= LIMIT);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj[BW-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        codes_d = fmt;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      blz_q   <= 1'b0;
      codes_q <= {NUM_DIGITS{BCD_CLEAR}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      blz_q   <= blz_d;
      codes_q <= codes_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign digit_codes = codes_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter with a
// scoreboard queue popped on every done pulse.
module tb_bcd_display_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic [15:0] digit_codes;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  bcd_display_formatter #(
    .NUM_DIGITS (4),
    .BIN_W      (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .done        (done),
    .digit_codes (digit_codes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [15:0] e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL unexpected_done: codes %h, none expected", digit_codes);
      end else begin
        e = sb.pop_front();
        assert (digit_codes === e) else begin
          fails++;
          $error("FAIL codes: got %h, expected %h", digit_codes, e);
        end
      end
    end
  end

  task automatic go(input int v, input bit b, input logic [15:0] e);
    @(negedge clk);
    value    = 14'(v);
    blank_lz = b;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles from acceptance to done and busy-high samples
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) return;
      cyc++;
    end
    tests++;
    fails++;
    $error("FAIL timeout: no done within 200 cycles");
  endtask

  task automatic conv(input string tag, input int v, input bit b,
                      input logic [15:0] e);
    int c, bc;
    go(v, b, e);
    wait_done(c, bc);
    chk({tag, "_lat"}, c, 15);
  endtask

  initial begin
    int c, bc, gap;
    rst      = 1'b1;
    start    = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_codes", int'(digit_codes), 16'hFFFF);

    go(1234, 1'b0, 16'h1234);
    wait_done(c, bc);
    chk("lat_1234", c, 15);
    chk("busy_cycles", bc, 15);
    chk("busy_at_done", int'(busy), 0);
    @(negedge clk);
    chk("done_single", int'(done), 0);
    chk("codes_hold", int'(digit_codes), 16'h1234);

    conv("blz7", 7, 1'b1, 16'hFFF7);
    conv("blz0", 0, 1'b1, 16'hFFF0);
    conv("blz305", 305, 1'b1, 16'hF305);
    conv("nblz7", 7, 1'b0, 16'h0007);
    conv("max9999", 9999, 1'b0, 16'h9999);
    conv("ovf10000", 10000, 1'b0, 16'hAAAA);
    conv("ovf16383", 16383, 1'b1, 16'hAAAA);

    // Start and input changes during a conversion are ignored
    go(100, 1'b1, 16'hF100);
    repeat (4) @(negedge clk);
    value    = 14'd42;
    blank_lz = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c, bc);
    chk("ign_lat", c, 10);
    repeat (20) @(negedge clk);
    chk("ign_idle", int'(busy), 0);

    // Held start: one result every 16 cycles
    @(negedge clk);
    value    = 14'd12;
    blank_lz = 1'b0;
    start    = 1'b1;
    repeat (3) sb.push_back(16'h0012);
    wait_done(c, bc);
    chk("b2b_first", c, 15);
    for (int n = 0; n < 2; n++) begin
      gap = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        gap++;
        if (done === 1'b1) break;
      end
      if (n == 1) start = 1'b0;
      chk("b2b_gap", gap, 16);
    end
    repeat (20) @(negedge clk);
    chk("b2b_stop", int'(busy), 0);
    chk("b2b_sb", sb.size(), 0);

    // Reset mid-conversion aborts without a done pulse
    go(77, 1'b0, 16'h0077);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_codes", int'(digit_codes), 16'hFFFF);
    repeat (20) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    conv("post56", 56, 1'b0, 16'h0056);

    // Reset and start on the same edge: reset wins
    @(negedge clk);
    value = 14'd99;
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_win_busy", int'(busy), 0);
    chk("rst_win_codes", int'(digit_codes), 16'hFFFF);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
